// File: rtl/btn_debounce_n.sv
// Multi-channel push-button debouncer with toggle, level and pulse modes.
// Buttons are sampled on a slow tick; long-press flag per channel.
module btn_debounce_n #(
    parameter int N          = 4,
    parameter int TICK_DIV   = 3125000,
    parameter int STABLE     = 3,
    parameter int LONG_TICKS = 40
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [N-1:0] nBIN,
    input  logic [1:0]   MODE,
    input  logic         CLR,
    output logic [N-1:0] BOUT,
    output logic [N-1:0] PRESS,
    output logic [N-1:0] RELEASE,
    output logic [N-1:0] LONG,
    output logic         TICK
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [3:0]    D_LAST  = 4'(STABLE - 1);
    localparam logic [HW-1:0] H_MAX   = HW'(LONG_TICKS);

    logic [CW-1:0]        cnt;
    logic                 tick;
    logic [N-1:0]         sync1;
    logic [N-1:0]         sync2;
    logic [N-1:0]         p;
    logic [N-1:0]         s;
    logic [N-1:0]         s_nxt;
    logic [N-1:0][3:0]    d;
    logic [N-1:0][3:0]    d_nxt;
    logic [N-1:0]         rise;
    logic [N-1:0]         fall;
    logic [N-1:0]         t;
    logic [N-1:0][HW-1:0] h;

    assign tick = (cnt == CNT_MAX);
    assign TICK = tick;
    assign p    = ~sync2;
    assign rise = s_nxt & ~s;
    assign fall = s & ~s_nxt;

    // Free-running sample-tick divider.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Two-flop synchroniser; idles at the released level.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= nBIN;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce decision: count disagreeing ticks, accept at STABLE.
    always_comb begin
        s_nxt = s;
        d_nxt = d;
        for (int i = 0; i < N; i++) begin
            if (tick) begin
                if (p[i] != s[i]) begin
                    if (d[i] == D_LAST) begin
                        s_nxt[i] = p[i];
                        d_nxt[i] = '0;
                    end else begin
                        d_nxt[i] = d[i] + 4'd1;
                    end
                end else begin
                    d_nxt[i] = '0;
                end
            end
        end
    end

    // Debounced state, debounce counters and edge strobes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s       <= '0;
            d       <= '0;
            PRESS   <= '0;
            RELEASE <= '0;
        end else begin
            s       <= s_nxt;
            d       <= d_nxt;
            PRESS   <= rise;
            RELEASE <= fall;
        end
    end

    // Toggle register; clear has priority over any toggle event.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            t <= '0;
        end else if (CLR) begin
            t <= '0;
        end else begin
            case (MODE)
                2'b00:   t <= t ^ PRESS;
                2'b01:   t <= t ^ (PRESS | RELEASE);
                default: t <= t;
            endcase
        end
    end

    // Mode-selected registered output; pulse mode lines up with PRESS.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            BOUT <= '0;
        end else begin
            case (MODE)
                2'b00, 2'b01: BOUT <= t;
                2'b10:        BOUT <= s;
                default:      BOUT <= rise;
            endcase
        end
    end

    // Hold counters: run while pressed, saturate at the long-press limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            h <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!s[i]) begin
                    h[i] <= '0;
                end else if (tick && (h[i] != H_MAX)) begin
                    h[i] <= h[i] + HW'(1);
                end
            end
        end
    end

    // Long-press level drops as soon as the release is accepted.
    always_comb begin
        LONG = '0;
        for (int i = 0; i < N; i++) begin
            LONG[i] = s[i] && (h[i] == H_MAX);
        end
    end

endmodule

// File: tb/tb_btn_debounce_n.sv
// Bench for btn_debounce_n: directed vector table, corner sequences
// and random stimulus against a behavioural reference model.
module tb_btn_debounce_n;

    localparam int P_N  = 4;
    localparam int P_TD = 4;
    localparam int P_ST = 3;
    localparam int P_LT = 8;

    logic           CLK = 1'b0;
    logic           nRST;
    logic [P_N-1:0] nBIN;
    logic [1:0]     MODE;
    logic           CLR;
    logic [P_N-1:0] BOUT;
    logic [P_N-1:0] PRESS;
    logic [P_N-1:0] RELEASE;
    logic [P_N-1:0] LONG;
    logic           TICK;

    btn_debounce_n #(
        .N(P_N), .TICK_DIV(P_TD), .STABLE(P_ST), .LONG_TICKS(P_LT)
    ) dut (
        .CLK(CLK), .nRST(nRST), .nBIN(nBIN), .MODE(MODE), .CLR(CLR),
        .BOUT(BOUT), .PRESS(PRESS), .RELEASE(RELEASE), .LONG(LONG),
        .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // reference model state
    int             m_cyc;
    logic [P_N-1:0] m_h1, m_h2;
    int             m_run [P_N];
    int             m_hold[P_N];
    logic [P_N-1:0] m_s, m_t, m_pr, m_rl, m_bo;

    int             edges2;
    logic           prev2;
    logic [P_N-1:0] any_rel;

    typedef struct {
        logic [3:0] nbin;
        logic [1:0] mode;
        int         cyc;
        logic [3:0] bout;
        logic [3:0] press;
        logic [3:0] rel;
        logic       tick;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_h1  = '1;
        m_h2  = '1;
        m_s   = '0;
        m_t   = '0;
        m_pr  = '0;
        m_rl  = '0;
        m_bo  = '0;
        for (int i = 0; i < P_N; i++) begin
            m_run[i]  = 0;
            m_hold[i] = 0;
        end
    endtask

    // one clock edge of the reference model, from the current inputs
    task automatic model_edge();
        logic           tk;
        logic [P_N-1:0] pl, ns, npr, nrl, nt, nbo;
        int             nrun[P_N];
        int             nh[P_N];
        tk = (m_cyc % P_TD) == (P_TD - 1);
        pl = ~m_h2;
        ns = m_s;
        for (int i = 0; i < P_N; i++) begin
            nrun[i] = m_run[i];
            if (tk) begin
                if (pl[i] != m_s[i]) begin
                    nrun[i] = m_run[i] + 1;
                    if (nrun[i] >= P_ST) begin
                        ns[i]   = pl[i];
                        nrun[i] = 0;
                    end
                end else begin
                    nrun[i] = 0;
                end
            end
            if (!m_s[i]) nh[i] = 0;
            else if (tk) nh[i] = (m_hold[i] + 1 > P_LT) ? P_LT : m_hold[i] + 1;
            else nh[i] = m_hold[i];
        end
        npr = ns & ~m_s;
        nrl = m_s & ~ns;
        if (CLR) nt = '0;
        else if (MODE == 2'd0) nt = m_t ^ m_pr;
        else if (MODE == 2'd1) nt = m_t ^ (m_pr | m_rl);
        else nt = m_t;
        if (MODE <= 2'd1) nbo = m_t;
        else if (MODE == 2'd2) nbo = m_s;
        else nbo = npr;
        m_s  = ns;
        m_pr = npr;
        m_rl = nrl;
        m_t  = nt;
        m_bo = nbo;
        for (int i = 0; i < P_N; i++) begin
            m_run[i]  = nrun[i];
            m_hold[i] = nh[i];
        end
        m_h2 = m_h1;
        m_h1 = nBIN;
        m_cyc++;
    endtask

    function automatic logic [16:0] model_out();
        logic [P_N-1:0] lg;
        for (int i = 0; i < P_N; i++) begin
            lg[i] = m_s[i] && (m_hold[i] == P_LT);
        end
        return {m_bo, m_pr, m_rl, lg, (m_cyc % P_TD) == (P_TD - 1)};
    endfunction

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check("model", 32'({BOUT, PRESS, RELEASE, LONG, TICK}),
              32'(model_out()));
        if (BOUT[2] !== prev2) edges2++;
        prev2   = BOUT[2];
        any_rel = any_rel | RELEASE;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #2;
        check("reset_out", 32'({BOUT, PRESS, RELEASE, LONG, TICK}), 32'd0);
        @(posedge CLK);
        #1;
        model_reset();
        prev2   = 1'b0;
        any_rel = '0;
        nRST    = 1'b1;
    endtask

    // kind 0 press, 1 release, 2 long; k = steps taken, -1 on timeout
    task automatic wait_ev(input int kind, input int ch, input int lim,
                           output int k);
        k = -1;
        for (int j = 1; j <= lim; j++) begin
            step();
            if ((kind == 0 && PRESS[ch]) || (kind == 1 && RELEASE[ch]) ||
                (kind == 2 && LONG[ch])) begin
                k = j;
                break;
            end
        end
    endtask

    task automatic hold_ch(input int ch, input logic lvl, input int n);
        nBIN[ch] = lvl;
        repeat (n) step();
    endtask

    initial begin
        int   k;
        logic pl;
        nRST = 1'b0;
        nBIN = '1;
        MODE = 2'd2;
        CLR  = 1'b0;
        model_reset();
        prev2   = 1'b0;
        any_rel = '0;
        edges2  = 0;

        tbl[0]  = '{4'hE, 2'd2, 3,  4'h0, 4'h0, 4'h0, 1'b1};
        tbl[1]  = '{4'hE, 2'd2, 8,  4'h0, 4'h0, 4'h0, 1'b1};
        tbl[2]  = '{4'hE, 2'd2, 1,  4'h0, 4'h1, 4'h0, 1'b0};
        tbl[3]  = '{4'hE, 2'd2, 1,  4'h1, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{4'hF, 2'd2, 11, 4'h1, 4'h0, 4'h1, 1'b0};
        tbl[5]  = '{4'hF, 2'd2, 1,  4'h0, 4'h0, 4'h0, 1'b0};
        tbl[6]  = '{4'hD, 2'd2, 7,  4'h0, 4'h0, 4'h0, 1'b0};
        tbl[7]  = '{4'hF, 2'd2, 12, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[8]  = '{4'hD, 2'd2, 11, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[9]  = '{4'hD, 2'd2, 1,  4'h0, 4'h2, 4'h0, 1'b0};
        tbl[10] = '{4'hF, 2'd2, 12, 4'h2, 4'h0, 4'h2, 1'b0};
        tbl[11] = '{4'hF, 2'd2, 1,  4'h0, 4'h0, 4'h0, 1'b0};

        // level mode timing, glitch rejection, debounce count clearing
        do_reset();
        for (int r = 0; r < 12; r++) begin
            nBIN = tbl[r].nbin;
            MODE = tbl[r].mode;
            repeat (tbl[r].cyc) step();
            check($sformatf("vec%0d", r),
                  32'({BOUT, PRESS, RELEASE, TICK}),
                  32'({tbl[r].bout, tbl[r].press, tbl[r].rel, tbl[r].tick}));
        end

        // toggle modes and mode switching on channel 2
        MODE = 2'd0;
        do_reset();
        hold_ch(2, 1'b0, 20); check("m0_p1", 32'(BOUT[2]), 32'd1);
        hold_ch(2, 1'b1, 20); check("m0_r1", 32'(BOUT[2]), 32'd1);
        MODE = 2'd2; step(); check("msw_lvl", 32'(BOUT[2]), 32'd0);
        MODE = 2'd0; step(); check("msw_back", 32'(BOUT[2]), 32'd1);
        hold_ch(2, 1'b0, 20); check("m0_p2", 32'(BOUT[2]), 32'd0);
        hold_ch(2, 1'b1, 20); check("m0_r2", 32'(BOUT[2]), 32'd0);
        MODE   = 2'd1;
        edges2 = 0;
        hold_ch(2, 1'b0, 20); check("m1_p1", 32'(BOUT[2]), 32'd1);
        hold_ch(2, 1'b1, 20); check("m1_r1", 32'(BOUT[2]), 32'd0);
        hold_ch(2, 1'b0, 20); check("m1_p2", 32'(BOUT[2]), 32'd1);
        hold_ch(2, 1'b1, 20); check("m1_r2", 32'(BOUT[2]), 32'd0);
        check("m1_toggles", 32'(edges2), 32'd4);

        // clear coinciding with a press strobe
        MODE = 2'd0;
        do_reset();
        nBIN = 4'hE;
        wait_ev(0, 0, 30, k);
        check("clr_press_lat", 32'(k), 32'd12);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        step();
        check("clr_bout", 32'(BOUT[0]), 32'd0);
        step();
        check("clr_bout2", 32'(BOUT[0]), 32'd0);
        nBIN = 4'hF;
        repeat (20) step();

        // long press, saturation, reset mid-hold, release clears LONG
        MODE = 2'd2;
        do_reset();
        nBIN = 4'h7;
        wait_ev(0, 3, 30, k);
        check("long_press_lat", 32'(k), 32'd12);
        wait_ev(2, 3, 60, k);
        check("long_lat", 32'(k), 32'd32);
        repeat (16) step();
        check("long_hold", 32'(LONG[3]), 32'd1);
        do_reset();
        wait_ev(0, 3, 30, k);
        check("rst_press_lat", 32'(k), 32'd12);
        check("rst_no_release", 32'(any_rel), 32'd0);
        wait_ev(2, 3, 60, k);
        check("long_lat2", 32'(k), 32'd32);
        nBIN = 4'hF;
        k    = -1;
        pl   = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            pl = LONG[3];
            step();
            if (RELEASE[3]) begin
                k = j;
                break;
            end
        end
        check("rel_found", 32'(k > 0), 32'd1);
        check("long_before_rel", 32'(pl), 32'd1);
        check("long_at_rel", 32'(LONG[3]), 32'd0);

        // random stimulus against the model
        MODE = 2'($urandom_range(0, 3));
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < P_N; i++) begin
                if ($urandom_range(0, 29) == 0) nBIN[i] = ~nBIN[i];
            end
            if ($urandom_range(0, 299) == 0) MODE = 2'($urandom_range(0, 3));
            CLR = ($urandom_range(0, 63) == 0);
            step();
        end
        CLR = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce_n.md
BTN_DEBOUNCE_N -- requirements
Module: btn_debounce_n

Interface
REQ-001 SHALL have parameter N, 4, number of button channels (1..16).
REQ-002 SHALL have parameter TICK_DIV, 3125000, CLK cycles per sample tick (>=2).
REQ-003 SHALL have parameter STABLE, 3, consecutive disagreeing ticks required to accept a new level (1..15).
REQ-004 SHALL have parameter LONG_TICKS, 40, ticks held before long-press flag (>=1).
REQ-005 SHALL have port CLK  input  1  system clock, all flops rising-edge.
REQ-006 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port nBIN  input  N  raw buttons, active-low (0 = pressed), asynchronous to CLK.
REQ-008 SHALL have port MODE  input  2  output mode: 00 toggle-on-press, 01 toggle-on-press-and-release, 10 level, 11 press pulse.
REQ-009 SHALL have port CLR  input  1  synchronous clear of all toggle state.
REQ-010 SHALL have port BOUT  output  N  mode-selected button output, registered.
REQ-011 SHALL have port PRESS  output  N  one-cycle debounced press strobe per channel.
REQ-012 SHALL have port RELEASE  output  N  one-cycle debounced release strobe per channel.
REQ-013 SHALL have port LONG  output  N  long-press level per channel.
REQ-014 SHALL have port TICK  output  1  one-cycle sample-tick strobe.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and wrap; TICK SHALL be high exactly in the cycle count = TICK_DIV-1.
REQ-016 Each nBIN bit SHALL pass a 2-flop synchroniser every CLK; pressed level p = inverted synchroniser output.
REQ-017 Each channel SHALL hold debounced state s and debounce count d; on TICK: if p != s, d increments; if p = s, d clears to 0.
REQ-018 When d would reach STABLE on a TICK, s SHALL take p and d SHALL clear in that same edge.
REQ-019 PRESS (RELEASE) SHALL be high for exactly the one cycle after the edge where s goes 0->1 (1->0); never both in one cycle for a channel.
REQ-020 A glitch shorter than STABLE consecutive ticks SHALL produce no s change and no strobe.
REQ-021 Toggle register t per channel SHALL invert on PRESS in MODE 00 and on PRESS or RELEASE in MODE 01; unchanged in modes 10/11.
REQ-022 CLR SHALL zero all t the next edge and SHALL win over a simultaneous toggle event.
REQ-023 BOUT SHALL be registered from: t (00, 01), s (10), PRESS-qualifying event (11, high the same cycle as PRESS); one cycle latency from its source.
REQ-024 MODE change SHALL NOT alter t; BOUT SHALL reflect the new mode on the next edge.
REQ-025 Hold counter h per channel SHALL clear while s = 0, increment on TICK while s = 1, saturate at LONG_TICKS.
REQ-026 LONG SHALL be 1 while h = LONG_TICKS and s = 1, clearing in the cycle after release is accepted.
REQ-027 Channels SHALL be independent; simultaneous events on several channels SHALL all be honoured in the same cycle.

Reset
REQ-028 nRST low SHALL immediately force: tick count 0, synchronisers 1 (released), s/d/t/h 0, BOUT/PRESS/RELEASE/LONG/TICK 0.
REQ-029 Reset deassertion with buttons held SHALL yield a PRESS after STABLE ticks, never a RELEASE first.
REQ-030 Reset mid-debounce or mid-hold SHALL discard the partial count.

Verification (N=4, TICK_DIV=4, STABLE=3, LONG_TICKS=8)
REQ-031 nBIN[0] low steady, MODE=10 -> PRESS[0] one cycle after 3rd TICK, BOUT[0]=1 one cycle later; TICK period 4 cycles.
REQ-032 nBIN[1] low for 2 ticks then high -> no PRESS[1], BOUT unchanged, d cleared.
REQ-033 MODE=00, two full press/release cycles on ch2 -> BOUT[2] 0->1->0; MODE=01 same stimulus -> four toggles, ends 0.
REQ-034 Hold ch3 for 12 ticks -> LONG[3]=1 after h reaches 8, stays 1, clears after release accepted; h saturates.
REQ-035 CLR pulsed in same cycle as PRESS[0] in MODE 00 -> t[0]=0, BOUT[0]=0.
REQ-036 nRST low mid-hold with LONG[3]=1 -> all outputs 0 immediately; button still held after release -> PRESS[3] after 3 ticks, no RELEASE.
